// File: rtl/serial_port_pkg.sv
// Shared types and constants for the serial_port UART.
package serial_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD     = 115_200;

    // Width of a counter running 0..clks_per_bit-1.
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/serial_port_rx.sv
// Receive path: 2-flop synchronizer and 8N1 receive FSM with valid and framing-error pulses.
module serial_port_rx
    import serial_port_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       ferr_o
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // Two cycles of synchronizer/edge latency are absorbed by sampling the start bit early.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 2);

    logic             sync1_q, sync2_q, prev_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             wait_q, wait_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wait_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wait_d  = wait_q;
        valid_o = 1'b0;
        ferr_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        wait_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // After a bad stop bit, hold here until the line idles high again.
                if (wait_q) begin
                    if (sync2_q) begin
                        state_d = IDLE;
                        wait_d  = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        valid_o = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_o = 1'b1;
                        wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/serial_port.sv
// 8N1 UART bus peripheral: transmit FSM, receive sub-module, interrupt and framing-error flags.
module serial_port
    import serial_port_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD         = DEFAULT_BAUD,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    output logic       int_req,
    input  logic       int_ack,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic       write_enable,
    input  logic       fuck1,
    output logic       fuck2,
    output logic       write_not_busy,
    output logic       TxD,
    input  logic       RxD
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_e           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;

    logic             int_req_q, fuck2_q;
    logic [7:0]       data_out_q;

    logic             rx_in;
    logic [7:0]       rx_byte;
    logic             rx_valid, rx_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // Line level is computed for the next state so TxD changes with the state register.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        unique case (tx_state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (write_enable) begin
                    tx_state_d = START;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_shift_d = data_in;
                    txd_d      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = DATA;
                    tx_cnt_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = IDLE;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    assign rx_in = fuck1 ? txd_q : RxD;

    serial_port_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i  (clk),
        .rst_i  (rst),
        .rx_i   (rx_in),
        .byte_o (rx_byte),
        .valid_o(rx_valid),
        .ferr_o (rx_ferr)
    );

    // A completing byte or error takes priority over a simultaneous acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_req_q  <= 1'b0;
            fuck2_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (rx_valid) begin
                int_req_q  <= 1'b1;
                data_out_q <= rx_byte;
            end else if (int_ack) begin
                int_req_q <= 1'b0;
            end
            if (rx_ferr) begin
                fuck2_q <= 1'b1;
            end else if (int_ack) begin
                fuck2_q <= 1'b0;
            end
        end
    end

    assign TxD            = txd_q;
    assign write_not_busy = (tx_state_q == IDLE);
    assign int_req        = int_req_q;
    assign fuck2          = fuck2_q;
    assign data_out       = data_out_q;

endmodule

// File: tb/tb_serial_port.sv
// Self-checking bench for serial_port at 4 clocks per bit.
module tb_serial_port;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_req;
    logic       int_ack;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic       write_enable;
    logic       fuck1;
    logic       fuck2;
    logic       write_not_busy;
    logic       TxD;
    logic       RxD;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] tx_q[$];
    logic       mon_en = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_irq;
        logic       exp_ferr;
    } rx_vec_t;

    rx_vec_t vec[6];

    serial_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .int_req       (int_req),
        .int_ack       (int_ack),
        .data_out      (data_out),
        .data_in       (data_in),
        .write_enable  (write_enable),
        .fuck1         (fuck1),
        .fuck2         (fuck2),
        .write_not_busy(write_not_busy),
        .TxD           (TxD),
        .RxD           (RxD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input logic expect_frame);
        @(posedge clk);
        #1;
        data_in      = d;
        write_enable = 1'b1;
        if (expect_frame) tx_q.push_back(d);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (write_not_busy) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s: write_not_busy stuck at 0 after 200 clocks, expected 1", name);
        end
    endtask

    // Drives start bit plus nbits data bits; with nbits=8 also puts the stop level on the line.
    task automatic rx_frame(input logic [7:0] d, input logic stop, input int nbits);
        @(posedge clk);
        #1;
        RxD = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            RxD = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (nbits == 8) RxD = stop;
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1;
        int_ack = 1'b1;
        @(posedge clk);
        #1;
        int_ack = 1'b0;
    endtask

    // Line-level decoder of TxD; compares each decoded frame with the queued expectation.
    initial begin : tx_monitor
        logic       prev;
        logic       st, sp;
        logic [7:0] b;
        logic [7:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !TxD && mon_en && !rst) begin
                repeat (2) @(negedge clk);
                st = TxD;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = TxD;
                end
                repeat (CPB) @(negedge clk);
                sp = TxD;
                if (tx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected_frame: got frame %0h, expected no frame", b);
                end else begin
                    exp = tx_q.pop_front();
                    check("tx_frame_byte", {24'd0, b}, {24'd0, exp});
                    check("tx_start_stop", {30'd0, st, sp}, 32'h1);
                end
                prev = sp;
            end else begin
                prev = TxD;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   busy;
        logic done;
        logic seen;

        vec[0] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
        vec[1] = '{8'h55, 1'b0, 8'h3C, 1'b0, 1'b1};
        vec[2] = '{8'hA7, 1'b1, 8'hA7, 1'b1, 1'b0};
        vec[3] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vec[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[5] = '{8'h80, 1'b0, 8'hFF, 1'b0, 1'b1};

        rst          = 1'b1;
        int_ack      = 1'b0;
        data_in      = 8'h00;
        write_enable = 1'b0;
        fuck1        = 1'b0;
        RxD          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("reset_txd", {31'd0, TxD}, 32'd1);
        check("reset_wnb", {31'd0, write_not_busy}, 32'd1);
        check("reset_int_req", {31'd0, int_req}, 32'd0);
        check("reset_fuck2", {31'd0, fuck2}, 32'd0);
        check("reset_data_out", {24'd0, data_out}, 32'd0);

        // A5 frame; a write of FF while busy must be dropped.
        write_byte(8'hA5, 1'b1);
        busy = 0;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (write_not_busy) begin
                done = 1'b1;
            end else begin
                busy++;
                if (busy == 10) begin
                    data_in      = 8'hFF;
                    write_enable = 1'b1;
                end else if (busy == 11) begin
                    write_enable = 1'b0;
                end
            end
        end
        check("tx_busy_clocks", busy, 32'd40);

        // Back-to-back write on the first idle cycle.
        data_in      = 8'h3C;
        write_enable = 1'b1;
        tx_q.push_back(8'h3C);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("tx_back_to_back_busy", {31'd0, write_not_busy}, 32'd0);
        wait_idle("tx_b2b_idle");
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            rx_frame(vec[i].data, vec[i].stop, 8);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("rx%0d_data_out", i), {24'd0, data_out}, {24'd0, vec[i].exp_data});
            check($sformatf("rx%0d_int_req", i), {31'd0, int_req}, {31'd0, vec[i].exp_irq});
            check($sformatf("rx%0d_fuck2", i), {31'd0, fuck2}, {31'd0, vec[i].exp_ferr});
            RxD = 1'b1;
            repeat (2 * CPB) @(posedge clk);
            ack_pulse();
            check($sformatf("rx%0d_ack_int_req", i), {31'd0, int_req}, 32'd0);
            check($sformatf("rx%0d_ack_fuck2", i), {31'd0, fuck2}, 32'd0);
            check($sformatf("rx%0d_ack_data_hold", i), {24'd0, data_out}, {24'd0, vec[i].exp_data});
        end

        // Acknowledge in the same cycle a byte completes: the set must win.
        rx_frame(8'hC3, 1'b1, 8);
        repeat (3) @(posedge clk);
        #1;
        int_ack = 1'b1;
        @(posedge clk);
        #1;
        int_ack = 1'b0;
        check("ack_collision_int_req", {31'd0, int_req}, 32'd1);
        check("ack_collision_data", {24'd0, data_out}, 32'hC3);

        // Overrun: second byte overwrites while int_req is still pending.
        repeat (2 * CPB) @(posedge clk);
        rx_frame(8'h5A, 1'b1, 8);
        repeat (4) @(posedge clk);
        #1;
        check("overrun_data", {24'd0, data_out}, 32'h5A);
        check("overrun_int_req", {31'd0, int_req}, 32'd1);
        ack_pulse();
        check("overrun_ack", {31'd0, int_req}, 32'd0);

        // Internal loopback.
        fuck1 = 1'b1;
        RxD   = 1'b1;
        write_byte(8'h81, 1'b1);
        wait_idle("loopback_idle");
        repeat (3) @(posedge clk);
        #1;
        check("loopback_data", {24'd0, data_out}, 32'h81);
        check("loopback_int_req", {31'd0, int_req}, 32'd1);
        ack_pulse();
        check("loopback_ack", {31'd0, int_req}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (int_req || fuck2) seen = 1'b1;
            end
            fuck1 = ~fuck1;
        end
        repeat (10) @(negedge clk);
        check("loop_toggle_spurious", {31'd0, seen | int_req | fuck2}, 32'd0);
        fuck1 = 1'b0;

        // Reset in the middle of a TX frame and an RX frame.
        rx_frame(8'h99, 1'b1, 8);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_int_req", {31'd0, int_req}, 32'd1);
        mon_en = 1'b0;
        write_byte(8'h0F, 1'b0);
        rx_frame(8'hF0, 1'b1, 4);
        check("pre_reset_busy", {31'd0, write_not_busy}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_txd", {31'd0, TxD}, 32'd1);
        check("midrst_wnb", {31'd0, write_not_busy}, 32'd1);
        check("midrst_int_req", {31'd0, int_req}, 32'd0);
        check("midrst_fuck2", {31'd0, fuck2}, 32'd0);
        check("midrst_data_out", {24'd0, data_out}, 32'd0);
        RxD = 1'b1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (int_req || fuck2 || !TxD || !write_not_busy) seen = 1'b1;
        end
        check("post_reset_quiet", {31'd0, seen}, 32'd0);
        mon_en = 1'b1;
        check("tx_queue_drained", tx_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_port.md
Name: serial_port

Overview:
- 8N1 UART peripheral for the MIPS CPU system bus.
- Transmitter accepts one byte per write strobe.
- Receiver delivers bytes on data_out and raises an interrupt request that the CPU acknowledges.
- Includes an internal loopback mode and a receive framing-error flag.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per serial bit; must be >= 4. The bench overrides it to 4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- int_req  out  1  receive interrupt request; a byte is waiting in data_out.
- int_ack  in  1  interrupt acknowledge; clears int_req and fuck2.
- data_out  out  8  last correctly received byte.
- data_in  in  8  byte to transmit.
- write_enable  in  1  single-cycle transmit strobe.
- fuck1  in  1  loopback enable, level: 1 = receiver input is internal TxD instead of RxD.
- fuck2  out  1  sticky receive framing-error flag.
- write_not_busy  out  1  1 = transmitter idle and able to accept a write.
- TxD  out  1  serial transmit line, idle high.
- RxD  in  1  serial receive line, asynchronous, idle high.

Behaviour:
- Reset values:
  - TxD=1, write_not_busy=1, int_req=0, fuck2=0, data_out=8'h00.
  - Both FSMs go to IDLE and all counters clear.
  - Reset asserted mid-frame aborts the frame immediately; no partial byte is delivered.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: write_enable=1 while write_not_busy=1. data_in is latched and write_not_busy drops on the next cycle.
  - write_enable while busy is ignored; the latched byte is unaffected.
  - Line sequence: START drives 0 for CLKS_PER_BIT clocks. DATA sends bits 0..7, LSB first, CLKS_PER_BIT clocks each. STOP drives 1 for CLKS_PER_BIT clocks.
  - After STOP: return to IDLE with write_not_busy=1.
  - Total busy time is 10*CLKS_PER_BIT clocks. Back-to-back writes are allowed on the cycle write_not_busy returns high.
  - TxD is registered (glitch-free).
- RX input path: the selected input (fuck1 ? TxD : RxD) passes through a 2-flop synchronizer. RxD is ignored while fuck1=1. Switching fuck1 mid-frame may corrupt that frame; that case is not checked beyond "no hang".
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: on a synchronized falling edge (1 -> 0).
  - In START, sample at CLKS_PER_BIT/2. If the sample is 1, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA samples 8 bits, each CLKS_PER_BIT after the previous sample (mid-bit), LSB first.
  - STOP samples the stop bit at mid-bit:
    - Stop = 1: data_out <= shift register and int_req <= 1, both in the same cycle. Return to IDLE.
    - Stop = 0: discard the byte (data_out unchanged) and set fuck2 <= 1. Wait for the line to return to 1 before re-entering IDLE.
- Interrupt:
  - int_ack=1 clears int_req and fuck2 on the next edge.
  - If a byte completes in the same cycle as int_ack, the set wins: int_req=1.
  - Overrun: a new byte overwrites data_out; int_req stays 1; no separate overrun flag.
- TX and RX operate fully independently, so full duplex is supported.

Decomposition:
- Shared package serial_port_pkg holds:
  - the FSM state enum (IDLE/START/DATA/STOP), common to TX and RX;
  - default CLK_FREQ and BAUD constants;
  - localparam width for the bit counter: $clog2(CLKS_PER_BIT).
- Natural sub-module: serial_port_rx (synchronizer plus receive FSM, outputs a byte with a valid pulse and a frame-error pulse).
- TX FSM and interrupt/flag registers stay in the top level.

Test Plan (CLKS_PER_BIT=4):
- Reset, then idle 20 clocks -> TxD=1, write_not_busy=1, int_req=0, fuck2=0, data_out=8'h00.
- Write data_in=8'hA5 with a 1-cycle write_enable:
  - Required: write_not_busy=0 for exactly 40 clocks.
  - Required: TxD carries 0, 1,0,1,0,0,1,0,1, 1, 4 clocks per bit.
  - A second write of 8'hFF during busy is ignored; the frame remains 8'hA5.
- Drive RxD with a frame of 8'h3C at 4 clk/bit -> within 2 clocks after the stop-bit midpoint, data_out=8'h3C and int_req=1. Then pulse int_ack -> int_req=0 next cycle; data_out holds 8'h3C.
- Frame 8'h55 with stop bit 0 -> fuck2=1, int_req=0, data_out unchanged. int_ack clears fuck2.
- fuck1=1 with RxD held at 1; write 8'h81 -> data_out=8'h81 and int_req=1 after the TX frame. Toggling fuck1 every 25 clocks while idle -> no spurious int_req or fuck2.
- Assert rst mid TX frame and mid RX frame -> all outputs return to reset values next cycle, and no int_req occurs afterwards.
